// File: rtl/regfile_ctrl.sv
// Write-port controller for the 16x32 register file: zero-fills the array after
// reset, arbitrates memory-load over ALU writeback, and tracks RAW/WAW hazards.
module regfile_ctrl #(
    parameter int INDEX_BIT_WIDTH = 4,
    parameter int DATA_BIT_WIDTH  = 32,
    parameter int N_REGS          = 1 << INDEX_BIT_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       init_done,

    input  logic                       m_valid,
    input  logic [INDEX_BIT_WIDTH-1:0] m_index,
    input  logic [DATA_BIT_WIDTH-1:0]  m_data,
    output logic                       m_ready,

    input  logic                       a_valid,
    input  logic [INDEX_BIT_WIDTH-1:0] a_index,
    input  logic [DATA_BIT_WIDTH-1:0]  a_data,
    output logic                       a_ready,

    input  logic                       iss_valid,
    input  logic                       iss_wr,
    input  logic [INDEX_BIT_WIDTH-1:0] iss_dst,
    input  logic [INDEX_BIT_WIDTH-1:0] iss_src1,
    input  logic [INDEX_BIT_WIDTH-1:0] iss_src2,
    output logic                       iss_stall,

    output logic                       rf_wrtEn,
    output logic [INDEX_BIT_WIDTH-1:0] rf_wrtIndex,
    output logic [DATA_BIT_WIDTH-1:0]  rf_dataIn
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [INDEX_BIT_WIDTH-1:0] LAST_IDX = INDEX_BIT_WIDTH'(N_REGS - 1);

    state_t                     state_q, state_d;
    logic [INDEX_BIT_WIDTH-1:0] cnt_q, cnt_d;
    logic [N_REGS-1:0]          busy_q, busy_d;
    logic                       issue_acc;

    // A register being written this cycle is readable through the regfile bypass,
    // so its busy bit does not count as a hazard.
    function automatic logic hazard(
        input logic [N_REGS-1:0]          busy,
        input logic                       wr_en,
        input logic [INDEX_BIT_WIDTH-1:0] wr_idx,
        input logic [INDEX_BIT_WIDTH-1:0] r
    );
        return busy[r] & ~(wr_en & (wr_idx == r));
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        busy_d      = busy_q;
        issue_acc   = 1'b0;
        init_done   = 1'b0;
        m_ready     = 1'b0;
        a_ready     = 1'b0;
        iss_stall   = 1'b0;
        rf_wrtEn    = 1'b0;
        rf_wrtIndex = '0;
        rf_dataIn   = '0;

        unique case (state_q)
            ST_INIT: begin
                rf_wrtEn    = 1'b1;
                rf_wrtIndex = cnt_q;
                iss_stall   = 1'b1;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end

            ST_RUN: begin
                init_done = 1'b1;
                m_ready   = m_valid;
                a_ready   = a_valid & ~m_valid;
                rf_wrtEn  = m_valid | a_valid;
                if (m_valid) begin
                    rf_wrtIndex = m_index;
                    rf_dataIn   = m_data;
                end else if (a_valid) begin
                    rf_wrtIndex = a_index;
                    rf_dataIn   = a_data;
                end

                iss_stall = iss_valid &
                            (hazard(busy_q, rf_wrtEn, rf_wrtIndex, iss_src1) |
                             hazard(busy_q, rf_wrtEn, rf_wrtIndex, iss_src2) |
                             (iss_wr & hazard(busy_q, rf_wrtEn, rf_wrtIndex, iss_dst)));
                issue_acc = iss_valid & iss_wr & ~iss_stall;

                // Clear first so a same-index issue in this cycle leaves the bit set.
                if (rf_wrtEn) begin
                    busy_d[rf_wrtIndex] = 1'b0;
                end
                if (issue_acc) begin
                    busy_d[iss_dst] = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_INIT;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: directed scenarios followed by randomized
// traffic, all outputs compared every cycle against a behavioural model.
module tb_regfile_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic        m_valid, a_valid;
    logic [3:0]  m_index, a_index;
    logic [31:0] m_data, a_data;
    logic        m_ready, a_ready;
    logic        iss_valid, iss_wr;
    logic [3:0]  iss_dst, iss_src1, iss_src2;
    logic        iss_stall;
    logic        rf_wrtEn;
    logic [3:0]  rf_wrtIndex;
    logic [31:0] rf_dataIn;

    int n_tests = 0;
    int n_fail  = 0;

    // Behavioural model state
    bit busy_m [16];
    bit filling = 1'b1;
    int fill_pos = 0;

    // Expected outputs for the current cycle
    bit       e_done, e_mr, e_ar, e_stall, e_en;
    int       e_idx;
    bit [31:0] e_data;

    bit a_hold;

    always #5 clk = ~clk;

    regfile_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .init_done   (init_done),
        .m_valid     (m_valid),
        .m_index     (m_index),
        .m_data      (m_data),
        .m_ready     (m_ready),
        .a_valid     (a_valid),
        .a_index     (a_index),
        .a_data      (a_data),
        .a_ready     (a_ready),
        .iss_valid   (iss_valid),
        .iss_wr      (iss_wr),
        .iss_dst     (iss_dst),
        .iss_src1    (iss_src1),
        .iss_src2    (iss_src2),
        .iss_stall   (iss_stall),
        .rf_wrtEn    (rf_wrtEn),
        .rf_wrtIndex (rf_wrtIndex),
        .rf_dataIn   (rf_dataIn)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit hz(input int r);
        return busy_m[r] && !(e_en && e_idx == r);
    endfunction

    task automatic model_outputs();
        if (filling) begin
            e_done = 0; e_mr = 0; e_ar = 0; e_stall = 1;
            e_en = 1; e_idx = fill_pos; e_data = 32'h0;
        end else begin
            e_done = 1;
            e_mr   = m_valid;
            e_ar   = a_valid && !m_valid;
            e_en   = m_valid || a_valid;
            if (m_valid) begin
                e_idx = int'(m_index); e_data = m_data;
            end else if (a_valid) begin
                e_idx = int'(a_index); e_data = a_data;
            end else begin
                e_idx = 0; e_data = 32'h0;
            end
            e_stall = iss_valid && (hz(int'(iss_src1)) || hz(int'(iss_src2)) ||
                                    (iss_wr && hz(int'(iss_dst))));
        end
    endtask

    task automatic model_update();
        if (reset) begin
            filling  = 1;
            fill_pos = 0;
            foreach (busy_m[i]) busy_m[i] = 0;
        end else if (filling) begin
            fill_pos++;
            if (fill_pos == 16) begin
                filling  = 0;
                fill_pos = 0;
            end
        end else begin
            if (e_en) busy_m[e_idx] = 0;
            if (iss_valid && iss_wr && !e_stall) busy_m[int'(iss_dst)] = 1;
        end
    endtask

    // One clock: compare every output mid-cycle, then advance the model at the edge.
    task automatic cycle();
        @(negedge clk);
        model_outputs();
        if (!reset) begin
            check_eq("init_done",   32'(init_done),   32'(e_done));
            check_eq("m_ready",     32'(m_ready),     32'(e_mr));
            check_eq("a_ready",     32'(a_ready),     32'(e_ar));
            check_eq("iss_stall",   32'(iss_stall),   32'(e_stall));
            check_eq("rf_wrtEn",    32'(rf_wrtEn),    32'(e_en));
            check_eq("rf_wrtIndex", 32'(rf_wrtIndex), 32'(e_idx));
            check_eq("rf_dataIn",   rf_dataIn,        e_data);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic idle_inputs();
        m_valid = 0; m_index = 0; m_data = 0;
        a_valid = 0; a_index = 0; a_data = 0;
        iss_valid = 0; iss_wr = 0; iss_dst = 0; iss_src1 = 0; iss_src2 = 0;
    endtask

    task automatic set_issue(input logic wr, input logic [3:0] dst,
                             input logic [3:0] s1, input logic [3:0] s2);
        iss_valid = 1; iss_wr = wr; iss_dst = dst; iss_src1 = s1; iss_src2 = s2;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        idle_inputs();

        // Power-up reset and fill
        repeat (3) cycle();
        reset = 0;
        #1;
        check_eq("t1_done_low",  32'(init_done),   32'd0);
        check_eq("t1_en_first",  32'(rf_wrtEn),    32'd1);
        check_eq("t1_idx_first", 32'(rf_wrtIndex), 32'd0);
        check_eq("t1_stall",     32'(iss_stall),   32'd1);
        repeat (16) cycle();
        #1;
        check_eq("t1_done_high", 32'(init_done), 32'd1);
        check_eq("t1_en_idle",   32'(rf_wrtEn),  32'd0);

        // RAW stall released by a same-cycle ALU write
        set_issue(1, 4'd5, 4'd1, 4'd2);
        #1 check_eq("t2_issue_ok", 32'(iss_stall), 32'd0);
        cycle();
        set_issue(1, 4'd6, 4'd5, 4'd0);
        #1 check_eq("t2_raw_stall", 32'(iss_stall), 32'd1);
        cycle();
        a_valid = 1; a_index = 4'd5; a_data = 32'hDEADBEEF;
        #1;
        check_eq("t2_stall_drop", 32'(iss_stall),   32'd0);
        check_eq("t2_wr_idx",     32'(rf_wrtIndex), 32'd5);
        check_eq("t2_wr_data",    rf_dataIn,        32'hDEADBEEF);
        cycle();
        a_valid = 0;
        set_issue(0, 4'd0, 4'd5, 4'd0);
        #1 check_eq("t2_busy5_clear", 32'(iss_stall), 32'd0);
        cycle();
        iss_valid = 0;
        a_valid = 1; a_index = 4'd6; a_data = 32'h66;
        cycle();
        a_valid = 0;

        // M over A priority, A held until accepted
        m_valid = 1; m_index = 4'd3; m_data = 32'h1111;
        a_valid = 1; a_index = 4'd7; a_data = 32'h2222;
        #1;
        check_eq("t3_m_ready", 32'(m_ready),     32'd1);
        check_eq("t3_a_wait",  32'(a_ready),     32'd0);
        check_eq("t3_idx_m",   32'(rf_wrtIndex), 32'd3);
        cycle();
        m_valid = 0;
        #1;
        check_eq("t3_a_ready", 32'(a_ready),     32'd1);
        check_eq("t3_idx_a",   32'(rf_wrtIndex), 32'd7);
        check_eq("t3_data_a",  rf_dataIn,        32'h2222);
        cycle();
        a_valid = 0;

        // Set wins over clear on the same index
        set_issue(1, 4'd4, 4'd0, 4'd0);
        cycle();
        m_valid = 1; m_index = 4'd4; m_data = 32'h44;
        #1 check_eq("t4_issue_ok", 32'(iss_stall), 32'd0);
        cycle();
        m_valid = 0;
        set_issue(0, 4'd0, 4'd4, 4'd0);
        #1 check_eq("t4_set_wins", 32'(iss_stall), 32'd1);
        cycle();

        // WAW stall leaves busy bits unchanged
        set_issue(1, 4'd9, 4'd0, 4'd0);
        cycle();
        #1 check_eq("t5_waw", 32'(iss_stall), 32'd1);
        cycle();
        set_issue(0, 4'd0, 4'd9, 4'd0);
        #1 check_eq("t5_busy9_kept", 32'(iss_stall), 32'd1);
        cycle();
        set_issue(0, 4'd0, 4'd0, 4'd0);
        #1 check_eq("t5_clean", 32'(iss_stall), 32'd0);
        cycle();
        iss_valid = 0;

        // Reset in RUN with busy bits set
        reset = 1;
        cycle();
        reset = 0;
        #1;
        check_eq("t6_done_low", 32'(init_done),   32'd0);
        check_eq("t6_idx0",     32'(rf_wrtIndex), 32'd0);
        repeat (16) cycle();
        set_issue(0, 4'd0, 4'd4, 4'd9);
        #1;
        check_eq("t6_done_high",    32'(init_done), 32'd1);
        check_eq("t6_busy_cleared", 32'(iss_stall), 32'd0);
        cycle();
        iss_valid = 0;

        // Reset in the middle of the fill
        reset = 1;
        cycle();
        reset = 0;
        repeat (8) cycle();
        #1 check_eq("t6_fill_idx8", 32'(rf_wrtIndex), 32'd8);
        reset = 1;
        cycle();
        reset = 0;
        #1;
        check_eq("t6_refill_idx0", 32'(rf_wrtIndex), 32'd0);
        check_eq("t6_refill_done", 32'(init_done),   32'd0);
        repeat (16) cycle();
        #1 check_eq("t6_refill_end", 32'(init_done), 32'd1);

        // Randomized traffic
        a_hold = 0;
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 299) == 0);
            m_valid = ($urandom_range(0, 9) < 3);
            m_index = 4'($urandom_range(0, 15));
            m_data  = $urandom;
            if (!a_hold) begin
                a_valid = ($urandom_range(0, 9) < 4);
                a_index = 4'($urandom_range(0, 15));
                a_data  = $urandom;
            end
            iss_valid = ($urandom_range(0, 9) < 6);
            iss_wr    = ($urandom_range(0, 3) != 0);
            iss_dst   = 4'($urandom_range(0, 15));
            iss_src1  = 4'($urandom_range(0, 15));
            iss_src2  = 4'($urandom_range(0, 15));
            cycle();
            a_hold = a_valid && !e_ar && !reset;
        end
        reset = 0;
        idle_inputs();
        cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_ctrl.md
Name: regfile_ctrl

Overview:
Controller in front of the 16x32 register file's single write port.
- After reset, sequences a zero-fill of every register, because the register file array has no reset.
- Then arbitrates the write port between two writeback sources: memory-load (M) and ALU (A).
- Keeps a per-register busy scoreboard and generates the issue-stage stall for RAW/WAW hazards.
- Sits between decode/issue, the writeback sources and the register file.

Parameters:
INDEX_BIT_WIDTH, 4, register index width
DATA_BIT_WIDTH, 32, data width
N_REGS, 1 << INDEX_BIT_WIDTH, number of registers cleared and tracked

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
init_done  out  1  high once zero-fill is complete
m_valid  in  1  memory-load writeback request
m_index  in  4  memory-load destination register
m_data  in  32  memory-load data
m_ready  out  1  memory-load request accepted this cycle
a_valid  in  1  ALU writeback request
a_index  in  4  ALU destination register
a_data  in  32  ALU data
a_ready  out  1  ALU request accepted this cycle
iss_valid  in  1  issue stage presenting an instruction
iss_wr  in  1  instruction writes a destination register
iss_dst  in  4  destination index
iss_src1  in  4  source index 1
iss_src2  in  4  source index 2
iss_stall  out  1  issue must hold
rf_wrtEn  out  1  register file write enable
rf_wrtIndex  out  4  register file write index
rf_dataIn  out  32  register file write data

Behaviour:
- FSM states: INIT, RUN. Reset forces INIT, init counter = 0, all busy bits = 0, init_done = 0.
- Reset mid-operation:
  - Abandons any fill in progress or pending writes.
  - Clears the scoreboard.
  - Restarts the fill from index 0.
- INIT:
  - rf_wrtEn=1, rf_wrtIndex=counter, rf_dataIn=0.
  - Counter increments each cycle.
  - m_ready=a_ready=0, iss_stall=1.
  - When counter == N_REGS-1, next state is RUN.
  - Fill takes exactly N_REGS cycles; init_done=1 on the first RUN cycle and stays 1 until reset.
- RUN write-port arbitration (combinational in-cycle; write commits at the next posedge):
  - Fixed priority M > A.
  - m_ready = m_valid. a_ready = a_valid & ~m_valid.
  - rf_wrtEn = m_valid | a_valid. Index and data are taken from the granted source; both are 0 when idle.
  - A losing source holds valid, index and data stable until it is accepted; the block does not buffer it.
- Scoreboard (one busy bit per register, RUN only):
  - Write clear: an accepted write to index i clears busy[i].
  - Issue set: an accepted issue sets busy[iss_dst]. An issue is accepted when iss_valid & iss_wr & ~iss_stall.
  - Same cycle, same index: set wins over clear.
- Stall rule (RUN):
  - iss_stall = iss_valid & (hazard(src1) | hazard(src2) | (iss_wr & hazard(dst))).
  - hazard(r) = busy[r] & ~(rf_wrtEn & rf_wrtIndex==r). This matches the register file's write-to-read bypass.
  - Both sources are checked regardless of opcode; a spurious stall is acceptable.
- Writeback to a non-busy register is legal and leaves busy unchanged.
- All outputs are 0 in RUN with no activity, except init_done.

Test Plan:
1. Reset held 3 cycles then released -> rf_wrtEn=1 for exactly 16 cycles; indices 0..15, data 0. init_done rises on cycle 17. iss_stall=1 and m_ready=a_ready=0 throughout the fill.
2. RUN, iss_valid=1, iss_wr=1, iss_dst=5, srcs 1/2 -> accepted, busy[5]=1. Next issue with src1=5 -> iss_stall=1. a_valid=1, a_index=5, a_data=0xDEADBEEF -> stall drops that same cycle; rf_wrtIndex=5; busy[5]=0 after the edge.
3. m_valid and a_valid both high (m_index=3, a_index=7) -> cycle 1: M written (m_ready=1, a_ready=0). Cycle 2, with A held: index 7 written, a_ready=1.
4. busy[4]=1; in one cycle an M write to 4 plus an accepted issue with dst=4 -> busy[4]=1 afterwards (set wins).
5. Issue with dst=9 while busy[9]=1 and no write to 9 -> iss_stall=1 (WAW); busy bits unchanged.
6. Reset asserted at fill index 8, or in RUN with busy bits set -> next cycle state INIT, counter 0, all busy 0, init_done=0; a full 16-cycle fill repeats.
